// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: access sizes, MMIO register
// offsets and the timer compare reset value.
package dmem_responder_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  localparam logic [31:0] OFF_MTIME_LO    = 32'h00;
  localparam logic [31:0] OFF_MTIME_HI    = 32'h04;
  localparam logic [31:0] OFF_MTIMECMP_LO = 32'h08;
  localparam logic [31:0] OFF_MTIMECMP_HI = 32'h0C;
  localparam logic [31:0] OFF_TOHOST      = 32'h10;
  localparam logic [31:0] MMIO_SPAN       = 32'h14;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/dmem_responder_mmio_timer.sv
// Machine timer: prescaler, 64-bit mtime/mtimecmp with CPU write port and
// a registered mtime >= mtimecmp interrupt.
module mmio_timer
  import dmem_responder_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset_x,
  input  logic        i_we,
  input  logic [1:0]  i_sel,
  input  logic [31:0] i_wdata,
  output logic [63:0] o_mtime,
  output logic [63:0] o_mtimecmp,
  output logic        o_irq
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   mtime_q, mtime_d, cmp_q, cmp_d;
  logic          irq_q, tick;

  assign tick  = (cnt_q == CW'(PRESCALE - 1));
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  // A CPU write to either mtime half wins over the prescaler increment.
  always_comb begin
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    cmp_d   = cmp_q;
    if (i_we) begin
      case (i_sel)
        2'd0: mtime_d = {mtime_q[63:32], i_wdata};
        2'd1: mtime_d = {i_wdata, mtime_q[31:0]};
        2'd2: cmp_d   = {cmp_q[63:32], i_wdata};
        default: cmp_d = {i_wdata, cmp_q[31:0]};
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      cnt_q   <= '0;
      mtime_q <= '0;
      cmp_q   <= MTIMECMP_RST;
      irq_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      irq_q   <= (mtime_q >= cmp_q);
    end
  end

  assign o_mtime    = mtime_q;
  assign o_mtimecmp = cmp_q;
  assign o_irq      = irq_q;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data slave: word RAM with byte/half lanes, machine timer and
// TOHOST register, plus misalignment and access-fault detection.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        reset_x,
  input  logic        i_memReq,
  input  logic        i_memWrite,
  input  logic [1:0]  i_memSize,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misaligned,
  output logic        o_accessFault,
  output logic        o_timerIrq,
  output logic [31:0] o_tohost,
  output logic        o_tohostValid
);

  localparam int          IDXW      = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

  logic [31:0] mem [RAM_WORDS];
  logic [31:0] mmio_off, ram_word, mmio_word, sel_word, lane_word, wdata_rep;
  logic [3:0]  be;
  logic [63:0] mtime, mtimecmp;
  logic        in_ram, in_mmio, mis, fault, ok, wr, ram_we, tmr_we, th_we;
  logic [31:0] tohost_q;
  logic        tohost_vld_q;

  assign mmio_off = i_addr - MMIO_BASE;
  assign in_ram   = i_addr < RAM_BYTES;
  assign in_mmio  = mmio_off < MMIO_SPAN;

  assign mis   = ((i_memSize == MEM_HALF) && i_addr[0]) ||
                 ((i_memSize == MEM_WORD) && (i_addr[1:0] != 2'b00));
  // MMIO registers only accept full-word accesses.
  assign fault = (i_memSize == 2'b11) ||
                 !(in_ram || (in_mmio && (i_memSize == MEM_WORD)));

  assign o_misaligned  = i_memReq && mis;
  assign o_accessFault = i_memReq && !mis && fault;
  assign ok            = i_memReq && !mis && !fault;
  assign wr            = ok && i_memWrite;
  assign ram_we        = wr && in_ram;
  assign tmr_we        = wr && !in_ram && !mmio_off[4];
  assign th_we         = wr && !in_ram && mmio_off[4];

  always_comb begin
    be        = 4'b1111;
    wdata_rep = i_wdata;
    case (i_memSize)
      MEM_BYTE: begin
        be        = 4'b0001 << i_addr[1:0];
        wdata_rep = {4{i_wdata[7:0]}};
      end
      MEM_HALF: begin
        be        = i_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{i_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[i_addr[IDXW+1:2]][8*b +: 8] <= wdata_rep[8*b +: 8];
    end
  end

  assign ram_word = mem[i_addr[IDXW+1:2]];

  always_comb begin
    mmio_word = tohost_q;
    case (mmio_off)
      OFF_MTIME_LO:    mmio_word = mtime[31:0];
      OFF_MTIME_HI:    mmio_word = mtime[63:32];
      OFF_MTIMECMP_LO: mmio_word = mtimecmp[31:0];
      OFF_MTIMECMP_HI: mmio_word = mtimecmp[63:32];
      default: ;
    endcase
  end

  assign sel_word  = in_ram ? ram_word : mmio_word;
  assign lane_word = sel_word >> {i_addr[1:0], 3'b000};

  always_comb begin
    o_rdata = 32'd0;
    if (ok) begin
      case (i_memSize)
        MEM_BYTE: o_rdata = {24'd0, lane_word[7:0]};
        MEM_HALF: o_rdata = {16'd0, lane_word[15:0]};
        default:  o_rdata = sel_word;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      tohost_q     <= '0;
      tohost_vld_q <= 1'b0;
    end else begin
      tohost_vld_q <= th_we;
      if (th_we) tohost_q <= i_wdata;
    end
  end

  assign o_tohost      = tohost_q;
  assign o_tohostValid = tohost_vld_q;

  mmio_timer #(.PRESCALE(PRESCALE)) u_timer (
    .clk        (clk),
    .reset_x    (reset_x),
    .i_we       (tmr_we),
    .i_sel      (mmio_off[3:2]),
    .i_wdata    (i_wdata),
    .o_mtime    (mtime),
    .o_mtimecmp (mtimecmp),
    .o_irq      (o_timerIrq)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM lanes, fault flags, timer, TOHOST
// and asynchronous reset.
module tb_dmem_responder;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam logic [1:0]  SB = 2'b00, SH = 2'b01, SW = 2'b10, SX = 2'b11;

  logic        clk = 1'b0;
  logic        reset_x;
  logic        memReq, memWrite;
  logic [1:0]  memSize;
  logic [31:0] addr, wdata;
  logic [31:0] rdata, tohost;
  logic        misal, afault, irq, thvld;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk           (clk),
    .reset_x       (reset_x),
    .i_memReq      (memReq),
    .i_memWrite    (memWrite),
    .i_memSize     (memSize),
    .i_addr        (addr),
    .i_wdata       (wdata),
    .o_rdata       (rdata),
    .o_misaligned  (misal),
    .o_accessFault (afault),
    .o_timerIrq    (irq),
    .o_tohost      (tohost),
    .o_tohostValid (thvld)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one access at the falling edge; it commits at the next rising edge.
  task automatic acc(input logic w, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] d);
    @(negedge clk);
    memReq = 1'b1; memWrite = w; memSize = sz; addr = a; wdata = d;
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    memReq = 1'b0; memWrite = 1'b0;
    #1;
  endtask

  initial begin
    reset_x = 1'b0;
    memReq = 1'b1; memWrite = 1'b0; memSize = SW; addr = BASE + 32'h4; wdata = '0;
    #12;
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_tohost", tohost, 32'd0);
    chk("rst_thvld", {31'd0, thvld}, 32'd0);
    chk("rst_mtime_hi", rdata, 32'd0);
    addr = BASE + 32'hC;
    #1 chk("rst_mtimecmp_hi", rdata, 32'hFFFF_FFFF);
    @(negedge clk);
    reset_x = 1'b1;

    // RAM lanes
    acc(1, SW, 32'h40, 32'hDEAD_BEEF);
    acc(0, SH, 32'h42, 0); chk("ld_half_42", rdata, 32'h0000_DEAD);
    acc(0, SB, 32'h41, 0); chk("ld_byte_41", rdata, 32'h0000_00BE);
    acc(0, SH, 32'h40, 0); chk("ld_half_40", rdata, 32'h0000_BEEF);
    acc(1, SB, 32'h43, 32'hFFFF_FF5A);
    acc(0, SW, 32'h40, 0); chk("ld_word_40", rdata, 32'h5AAD_BEEF);
    acc(1, SW, 32'h44, 32'h0);
    acc(1, SH, 32'h46, 32'hAAAA_1234);
    acc(0, SW, 32'h44, 0); chk("ld_word_44", rdata, 32'h1234_0000);

    // Alignment and faults
    acc(0, SW, 32'h42, 0);
    chk("mis_ld_flag", {31'd0, misal}, 32'd1);
    chk("mis_ld_fault", {31'd0, afault}, 32'd0);
    chk("mis_ld_rdata", rdata, 32'd0);
    acc(1, SW, 32'h42, 32'h1111_1111); chk("mis_st_flag", {31'd0, misal}, 32'd1);
    acc(1, SH, 32'h41, 32'h2222_2222); chk("mis_half_flag", {31'd0, misal}, 32'd1);
    acc(0, SW, 32'h40, 0); chk("ram_unchanged", rdata, 32'h5AAD_BEEF);
    acc(1, SW, 32'h1000, 32'h5); chk("oob_fault", {31'd0, afault}, 32'd1);
    chk("oob_mis", {31'd0, misal}, 32'd0);
    acc(0, SX, 32'h40, 0); chk("size11_fault", {31'd0, afault}, 32'd1);
    chk("size11_rdata", rdata, 32'd0);
    acc(0, SH, BASE, 0); chk("mmio_half_fault", {31'd0, afault}, 32'd1);
    acc(0, SW, BASE + 32'h14, 0); chk("mmio_hole_fault", {31'd0, afault}, 32'd1);
    acc(0, SW, BASE + 32'h2, 0); chk("mmio_mis_prio", {30'd0, misal, afault}, 32'd2);
    @(negedge clk); memReq = 1'b0; memSize = SW; addr = 32'h42; #1;
    chk("noreq_flags", {30'd0, misal, afault}, 32'd0);

    // Timer: mtime forced to 0, compare at 20
    acc(1, SW, BASE + 32'hC, 32'd0);
    acc(1, SW, BASE + 32'h0, 32'd0);
    acc(1, SW, BASE + 32'h4, 32'd0);
    acc(1, SW, BASE + 32'h8, 32'd20);
    for (int k = 1; k <= 25; k++) begin
      acc(0, SW, BASE, 0);
      chk($sformatf("mtime_%0d", k), rdata, 32'(k));
      chk($sformatf("irq_%0d", k), {31'd0, irq}, {31'd0, (k >= 21)});
    end
    acc(1, SW, BASE + 32'hC, 32'd1); chk("irq_before_hi", {31'd0, irq}, 32'd1);
    acc(0, SW, BASE + 32'hC, 0);     chk("cmp_hi_rd", rdata, 32'd1);
    chk("irq_lag", {31'd0, irq}, 32'd1);
    acc(0, SW, BASE + 32'h8, 0);     chk("irq_fall", {31'd0, irq}, 32'd0);
    chk("cmp_lo_rd", rdata, 32'd20);

    // mtime carry into the high half; write beats increment
    acc(1, SW, BASE + 32'h0, 32'hFFFF_FFFF);
    acc(1, SW, BASE + 32'h4, 32'h0);
    acc(0, SW, BASE + 32'h0, 0); chk("wrap_lo_pre", rdata, 32'hFFFF_FFFF);
    acc(0, SW, BASE + 32'h4, 0); chk("wrap_hi", rdata, 32'd1);
    acc(0, SW, BASE + 32'h0, 0); chk("wrap_lo_post", rdata, 32'd1);
    acc(1, SW, BASE + 32'h0, 32'h100);
    acc(0, SW, BASE + 32'h0, 0); chk("wr_beats_inc", rdata, 32'h100);
    acc(0, SW, BASE + 32'h0, 0); chk("inc_after_wr", rdata, 32'h101);

    // TOHOST
    acc(1, SW, BASE + 32'h10, 32'h1); chk("th_vld_pre", {31'd0, thvld}, 32'd0);
    idle(); chk("th_val", tohost, 32'd1); chk("th_vld", {31'd0, thvld}, 32'd1);
    idle(); chk("th_vld_off", {31'd0, thvld}, 32'd0); chk("th_hold", tohost, 32'd1);
    acc(1, SW, BASE + 32'h10, 32'h2);
    acc(1, SW, BASE + 32'h10, 32'h3);
    chk("b2b_vld1", {31'd0, thvld}, 32'd1); chk("b2b_val1", tohost, 32'd2);
    acc(0, SW, BASE + 32'h10, 0);
    chk("b2b_vld2", {31'd0, thvld}, 32'd1); chk("th_rd", rdata, 32'd3);
    idle(); chk("b2b_vld_off", {31'd0, thvld}, 32'd0);

    // Reset mid-run with irq and tohostValid both high
    acc(1, SW, BASE + 32'hC, 32'd0);
    acc(1, SW, BASE + 32'h8, 32'd0);
    acc(1, SW, BASE + 32'h10, 32'h55);
    idle();
    chk("pre_rst_irq", {31'd0, irq}, 32'd1);
    chk("pre_rst_thvld", {31'd0, thvld}, 32'd1);
    reset_x = 1'b0;
    memReq = 1'b1; memWrite = 1'b0; memSize = SW; addr = BASE;
    #1;
    chk("mid_rst_irq", {31'd0, irq}, 32'd0);
    chk("mid_rst_thvld", {31'd0, thvld}, 32'd0);
    chk("mid_rst_tohost", tohost, 32'd0);
    chk("mid_rst_mtime_lo", rdata, 32'd0);
    addr = BASE + 32'h4; #1 chk("mid_rst_mtime_hi", rdata, 32'd0);
    addr = BASE + 32'h8; #1 chk("mid_rst_cmp_lo", rdata, 32'hFFFF_FFFF);
    @(negedge clk); reset_x = 1'b1; memReq = 1'b0;
    idle();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
